controle_teclas: RTL and testbench

Front-end controller for the board push-buttons that drive the Nano processor (step, run, reset-PC, mode).
- Filters N raw keys and converts each debounced press into exactly one event code.
- Shares a single event channel between all keys using a round-robin arbiter.
- Buffers events in a small FIFO that the processor control logic drains with a valid/ready handshake.

---
 rtl/ctrl_teclas_pkg.sv | 15 +
 rtl/filtro_tecla.sv | 42 ++++
 rtl/controle_teclas.sv | 104 ++++++++++
 tb/tb_controle_teclas.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_teclas_pkg.sv
// rtl/ctrl_teclas_pkg.sv - default constants and clog2 helper for the key controller
package ctrl_teclas_pkg;

  localparam int N_KEYS_DEF          = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 139968;
  localparam int FIFO_DEPTH_DEF      = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/filtro_tecla.sv
// rtl/filtro_tecla.sv - single-key two-flop synchronizer and debounce counter
module filtro_tecla
  import ctrl_teclas_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_state
);

  localparam int CNT_W = clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_0;
  logic             sync_1;
  logic [CNT_W-1:0] cnt;

  // The counter only runs while the synchronized level disagrees with the
  // debounced level, so any bounce shorter than the window resets it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_0    <= 1'b0;
      sync_1    <= 1'b0;
      cnt       <= '0;
      key_state <= 1'b0;
    end else begin
      sync_0 <= key_raw;
      sync_1 <= sync_0;
      if (sync_1 == key_state) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        key_state <= sync_1;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/controle_teclas.sv
// rtl/controle_teclas.sv - debounced push-button events, round-robin arbitration into a small FIFO
module controle_teclas
  import ctrl_teclas_pkg::*;
#(
  parameter int N_KEYS          = N_KEYS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF,
  parameter int CODE_W          = clog2(N_KEYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_state,
  output logic [CODE_W-1:0] evt_code,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic              overflow
);

  localparam int AW = clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  logic [N_KEYS-1:0] state_q;
  logic [N_KEYS-1:0] pending;
  logic [N_KEYS-1:0] rise;
  logic [N_KEYS-1:0] gnt_mask;
  logic [CODE_W-1:0] ptr;
  logic [CODE_W-1:0] gnt_idx;
  logic [CODE_W-1:0] scan_idx;
  logic              gnt_valid;
  logic [CODE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              full;
  logic              pop;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_filtro
    filtro_tecla #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filtro (
      .clk      (clk),
      .rst      (rst),
      .key_raw  (key_raw[i]),
      .key_state(key_state[i])
    );
  end

  assign rise      = key_state & ~state_q;
  assign full      = (count == FULL_COUNT);
  assign evt_valid = (count != '0);
  assign pop       = evt_valid & evt_ready;
  assign evt_code  = evt_valid ? mem[rd_ptr] : '0;

  // Scan from the farthest offset down so the closest pending key at or
  // after ptr is the last one to claim the grant.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    if (!full) begin
      for (int j = N_KEYS - 1; j >= 0; j--) begin
        scan_idx = CODE_W'((int'(ptr) + j) % N_KEYS);
        if (pending[scan_idx]) begin
          gnt_valid = 1'b1;
          gnt_idx   = scan_idx;
        end
      end
    end
    gnt_mask = gnt_valid ? (N_KEYS'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      ptr      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state_q <= key_state;
      // A rise on a key whose grant lands this very cycle re-arms it cleanly.
      pending <= (pending & ~gnt_mask) | rise;
      if (|(rise & pending & ~gnt_mask)) overflow <= 1'b1;
      if (gnt_valid) begin
        wr_ptr <= wr_ptr + AW'(1);
        ptr    <= (gnt_idx == CODE_W'(N_KEYS - 1)) ? '0 : gnt_idx + CODE_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({gnt_valid, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (gnt_valid) mem[wr_ptr] <= gnt_idx;
  end

endmodule

// File: tb/tb_controle_teclas.sv
// tb/tb_controle_teclas.sv - directed self-checking bench for controle_teclas
module tb_controle_teclas;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_raw;
  logic [3:0] key_state;
  logic [1:0] evt_code;
  logic       evt_valid;
  logic       evt_ready;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int ev_code[$];
  int ev_cyc[$];

  always #5 clk = ~clk;

  controle_teclas #(
    .N_KEYS(4),
    .DEBOUNCE_CYCLES(8),
    .FIFO_DEPTH(4),
    .CODE_W(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_raw  (key_raw),
    .key_state(key_state),
    .evt_code (evt_code),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .overflow (overflow)
  );

  // Logs the head that is popped at the coming edge, tagged with the sample index it was visible at.
  task automatic tick();
    if (evt_valid && evt_ready) begin
      ev_code.push_back(int'(evt_code));
      ev_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_ev();
    ev_code.delete();
    ev_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; key_raw = 4'b0000; evt_ready = 1'b0;
    tick(); tick();
    n_vec++; if (key_state !== 4'b0000) begin n_err++; $display("FAIL reset_key_state: got %b expected 0000", key_state); end
    n_vec++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL reset_evt_valid: got %b expected 0", evt_valid); end
    n_vec++; if (evt_code !== 2'd0) begin n_err++; $display("FAIL reset_evt_code: got %0d expected 0", evt_code); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    rst = 1'b0;
    run(3);
  endtask

  task automatic test_clean_press();
    int rise_c, vcount, base;
    rise_c = -1; vcount = 0; clear_ev(); evt_ready = 1'b1;
    base = cyc; key_raw[2] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (key_state[2] && rise_c < 0) rise_c = c;
      if (evt_valid) vcount++;
      if (c == 20) key_raw[2] = 1'b0;
    end
    n_vec++; if (rise_c !== 10) begin n_err++; $display("FAIL clean_rise_latency: got %0d expected 10", rise_c); end
    n_vec++; if (vcount !== 1) begin n_err++; $display("FAIL clean_valid_cycles: got %0d expected 1", vcount); end
    n_vec++; if (ev_code.size() !== 1) begin n_err++; $display("FAIL clean_event_count: got %0d expected 1", ev_code.size()); end
    n_vec++; if (ev_code[0] !== 2) begin n_err++; $display("FAIL clean_event_code: got %0d expected 2", ev_code[0]); end
    n_vec++; if (ev_cyc[0] - base !== 12) begin n_err++; $display("FAIL clean_event_latency: got %0d expected 12", ev_cyc[0] - base); end
    n_vec++; if (key_state !== 4'b0000) begin n_err++; $display("FAIL clean_released: got %b expected 0000", key_state); end
  endtask

  task automatic test_bounce();
    int changes;
    changes = 0; clear_ev(); evt_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      key_raw[1] = ((c / 3) % 2 == 0);
      tick();
      if (key_state[1] !== 1'b0) changes++;
    end
    n_vec++; if (changes !== 0) begin n_err++; $display("FAIL bounce_state_toggles: got %0d expected 0", changes); end
    n_vec++; if (ev_code.size() !== 0) begin n_err++; $display("FAIL bounce_early_events: got %0d expected 0", ev_code.size()); end
    key_raw[1] = 1'b1;
    run(25);
    n_vec++; if (key_state[1] !== 1'b1) begin n_err++; $display("FAIL bounce_settled_state: got %b expected 1", key_state[1]); end
    key_raw[1] = 1'b0;
    run(15);
    n_vec++; if (ev_code.size() !== 1) begin n_err++; $display("FAIL bounce_event_count: got %0d expected 1", ev_code.size()); end
    n_vec++; if (ev_code[0] !== 1) begin n_err++; $display("FAIL bounce_event_code: got %0d expected 1", ev_code[0]); end
  endtask

  task automatic test_simultaneous();
    int exp1[3];
    exp1 = '{0, 1, 3};
    do_reset();
    clear_ev(); evt_ready = 1'b1;
    key_raw = 4'b1011;
    run(20);
    key_raw = 4'b0000;
    run(15);
    n_vec++; if (ev_code.size() !== 3) begin n_err++; $display("FAIL simul_event_count: got %0d expected 3", ev_code.size()); end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (ev_code[i] !== exp1[i]) begin n_err++; $display("FAIL simul_order[%0d]: got %0d expected %0d", i, ev_code[i], exp1[i]); end
    end
    n_vec++; if (ev_cyc[1] !== ev_cyc[0] + 1 || ev_cyc[2] !== ev_cyc[1] + 1) begin
      n_err++; $display("FAIL simul_back_to_back: got cycles %0d %0d %0d expected consecutive", ev_cyc[0], ev_cyc[1], ev_cyc[2]);
    end
    clear_ev();
    key_raw = 4'b1001;
    run(20);
    key_raw = 4'b0000;
    run(15);
    n_vec++; if (ev_code.size() !== 2) begin n_err++; $display("FAIL simul2_event_count: got %0d expected 2", ev_code.size()); end
    n_vec++; if (ev_code[0] !== 0 || ev_code[1] !== 3) begin n_err++; $display("FAIL simul2_order: got %0d,%0d expected 0,3", ev_code[0], ev_code[1]); end
  endtask

  task automatic test_backpressure();
    int exp4[5];
    exp4 = '{0, 1, 2, 3, 0};
    do_reset();
    clear_ev(); evt_ready = 1'b0;
    key_raw = 4'b1111;
    run(16);
    n_vec++; if (evt_valid !== 1'b1 || evt_code !== 2'd0) begin n_err++; $display("FAIL full_head: got valid=%b code=%0d expected valid=1 code=0", evt_valid, evt_code); end
    key_raw[0] = 1'b0;
    run(12);
    key_raw[0] = 1'b1;
    run(14);
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_no_overflow: got %b expected 0", overflow); end
    n_vec++; if (evt_code !== 2'd0) begin n_err++; $display("FAIL full_head_stable: got %0d expected 0", evt_code); end
    evt_ready = 1'b1;
    run(15);
    key_raw = 4'b0000;
    run(15);
    n_vec++; if (ev_code.size() !== 5) begin n_err++; $display("FAIL drain_count: got %0d expected 5", ev_code.size()); end
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (ev_code[i] !== exp4[i]) begin n_err++; $display("FAIL drain_order[%0d]: got %0d expected %0d", i, ev_code[i], exp4[i]); end
    end
  endtask

  task automatic test_overflow();
    int exp5[5];
    exp5 = '{0, 1, 3, 0, 2};
    do_reset();
    clear_ev(); evt_ready = 1'b0;
    key_raw = 4'b1011;
    run(16);
    key_raw[0] = 1'b0;
    run(12);
    key_raw[0] = 1'b1;
    run(14);
    key_raw[2] = 1'b1;
    run(14);
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_before_repress: got %b expected 0", overflow); end
    key_raw[2] = 1'b0;
    run(12);
    key_raw[2] = 1'b1;
    run(14);
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    evt_ready = 1'b1;
    run(15);
    key_raw = 4'b0000;
    run(15);
    n_vec++; if (ev_code.size() !== 5) begin n_err++; $display("FAIL ovf_drain_count: got %0d expected 5", ev_code.size()); end
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (ev_code[i] !== exp5[i]) begin n_err++; $display("FAIL ovf_drain_order[%0d]: got %0d expected %0d", i, ev_code[i], exp5[i]); end
    end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_reset_mid();
    int base;
    clear_ev(); evt_ready = 1'b0;
    key_raw = 4'b1011;
    run(16);
    n_vec++; if (evt_valid !== 1'b1 || overflow !== 1'b1) begin n_err++; $display("FAIL midrst_pre: got valid=%b ovf=%b expected 1,1", evt_valid, overflow); end
    key_raw = 4'b0001;
    base = cyc;
    do_reset();
    n_vec++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b expected 0", evt_valid); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL midrst_overflow: got %b expected 0", overflow); end
    n_vec++; if (key_state !== 4'b0000) begin n_err++; $display("FAIL midrst_key_state: got %b expected 0000", key_state); end
    evt_ready = 1'b1;
    run(20);
    key_raw = 4'b0000;
    run(12);
    n_vec++; if (ev_code.size() !== 1) begin n_err++; $display("FAIL midrst_event_count: got %0d expected 1", ev_code.size()); end
    n_vec++; if (ev_code[0] !== 0) begin n_err++; $display("FAIL midrst_event_code: got %0d expected 0", ev_code[0]); end
    n_vec++; if (ev_cyc[0] - base !== 13) begin n_err++; $display("FAIL midrst_latency: got %0d expected 13", ev_cyc[0] - base); end
  endtask

  initial begin
    rst = 1'b1; key_raw = 4'b0000; evt_ready = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
